// File: rtl/iterative_shift_unit_pkg.sv
// Shared definitions for the iterative shifter: FSM state encoding and per-step limit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iterative_shift_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Largest shift done in one clock; sized to a 2-bit barrel select.
    localparam int MAX_STEP = 3;

endpackage

// File: rtl/iterative_shift_unit_shift_step.sv
// Combinational 0..3-bit logical shift with zero fill (one iteration of the shifter).
// Latency: 0 cycles, purely combinational.
// Backpressure: none, no handshake.
// Ports: data (word in), step (shift amount 0..3), dir (0 right, 1 left), shifted (word out).
module shift_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       step,
    input  logic             dir,
    output logic [WIDTH-1:0] shifted
);

    logic [WIDTH-1:0] stage1;
    logic [WIDTH-1:0] by1;
    logic [WIDTH-1:0] by2;

    // Two mux stages (1-bit then 2-bit), same shape as the downstream barrel shifter.
    assign by1     = dir ? (data << 1) : (data >> 1);
    assign stage1  = step[0] ? by1 : data;
    assign by2     = dir ? (stage1 << 2) : (stage1 >> 2);
    assign shifted = step[1] ? by2 : stage1;

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle logical shifter: shifts a WIDTH-bit word by in_amt, at most MAX_STEP bits per clock.
// Latency: accept to out_valid is 1 cycle for amt 0, else 1 + ceil(min(amt,WIDTH)/3) cycles.
// Backpressure: single request in flight; in_ready low in BUSY/DONE; result holds while out_ready low.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data/in_amt/in_dir request side;
//        out_valid/out_ready/out_data result side; busy high while a request is in flight.
module iterative_shift_unit
    import iterative_shift_unit_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int AMT_W    = 4,
    parameter int MAX_STEP = iterative_shift_unit_pkg::MAX_STEP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    // One extra bit so the clamp value WIDTH always fits.
    localparam int REM_W = AMT_W + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;

    logic [REM_W-1:0] amt_clamp;
    logic [1:0]       step;
    logic [REM_W-1:0] rem_left;
    logic [WIDTH-1:0] step_out;

    // Anything at or beyond WIDTH empties the word; stopping at WIDTH bounds the step count.
    assign amt_clamp = (int'(in_amt) > WIDTH) ? REM_W'(WIDTH) : {1'b0, in_amt};

    assign step     = (rem_q > REM_W'(MAX_STEP)) ? 2'(MAX_STEP) : rem_q[1:0];
    assign rem_left = rem_q - REM_W'(step);

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data    (data_q),
        .step    (step),
        .dir     (dir_q),
        .shifted (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    dir_d   = in_dir;
                    rem_d   = amt_clamp;
                    state_d = (amt_clamp == '0) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                data_d = step_out;
                rem_d  = rem_left;
                if (rem_left == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // data_q untouched here, so the result holds under backpressure.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY) || (state_q == ST_DONE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed bench for iterative_shift_unit (16-bit main instance plus an 8-bit instance for clamping).
// Latency: n/a.
// Backpressure: exercised by holding out_ready low during DONE.
module tb_iterative_shift_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic        in_dir;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  in_data8;
    logic [3:0]  in_amt8;
    logic        in_dir8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  out_data8;
    logic        busy8;

    int n_tests = 0;
    int n_fail  = 0;

    iterative_shift_unit #(
        .WIDTH (16),
        .AMT_W (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    iterative_shift_unit #(
        .WIDTH (8),
        .AMT_W (4)
    ) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_data   (in_data8),
        .in_amt    (in_amt8),
        .in_dir    (in_dir8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8),
        .busy      (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present one request at a negedge; it is accepted on the following posedge.
    task automatic issue(input string tag, input logic [15:0] d, input logic [3:0] a, input logic dir);
        @(negedge clk);
        check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_dir   = dir;
        @(posedge clk);
    endtask

    // Called right after the accept edge. lat counts cycles from the accept edge,
    // 1 meaning out_valid is already up in the cycle that edge starts.
    task automatic wait_result(input string tag, input logic [15:0] exp_data, input int exp_lat);
        int lat;
        int bcnt;
        lat  = 1;
        bcnt = 0;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        in_amt   = 4'd1;
        in_dir   = ~in_dir;
        while (!out_valid && lat < 64) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_busycyc"}, 32'(bcnt), 32'(exp_lat - 1));
        check_eq({tag, "_data"}, 32'(out_data), 32'(exp_data));
        if (out_ready) begin
            @(negedge clk);
            check_eq({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
            check_eq({tag, "_vld_after"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        int lat;
        int vcnt;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_amt     = '0;
        in_dir     = 1'b0;
        out_ready  = 1'b1;
        in_valid8  = 1'b0;
        in_data8   = '0;
        in_amt8    = '0;
        in_dir8    = 1'b0;
        out_ready8 = 1'b1;

        #3;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Right 7: steps 3,3,1.
        issue("right7", 16'hF00F, 4'd7, 1'b0);
        wait_result("right7", 16'h01E0, 4);
        // Left 5: steps 3,2.
        issue("left5", 16'h0001, 4'd5, 1'b1);
        wait_result("left5", 16'h0020, 3);
        // Zero amount goes straight to DONE.
        issue("zero", 16'hA5A5, 4'd0, 1'b0);
        wait_result("zero", 16'hA5A5, 1);
        // Max amount: five steps (3,3,3,3,3).
        issue("max_r", 16'hFFFF, 4'd15, 1'b0);
        wait_result("max_r", 16'h0001, 6);
        issue("max_l", 16'hFFFF, 4'd15, 1'b1);
        wait_result("max_l", 16'h8000, 6);

        // Backpressure: amt 4 left, result held for 6 cycles while a second request waits.
        out_ready = 1'b0;
        issue("bp", 16'h00F0, 4'd4, 1'b1);
        wait_result("bp", 16'h0F00, 3);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0003;
            in_amt   = 4'd2;
            in_dir   = 1'b1;
            @(negedge clk);
            check_eq("bp_hold_vld", 32'(out_valid), 32'd1);
            check_eq("bp_hold_data", 32'(out_data), 32'h0F00);
            check_eq("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_handoff_rdy", 32'(in_ready), 32'd1);
        check_eq("bp_handoff_vld", 32'(out_valid), 32'd0);
        @(posedge clk);
        wait_result("bp2", 16'h000C, 2);

        // Async reset in the middle of a BUSY phase.
        issue("rstmid", 16'h0F0F, 4'd9, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("rstmid_busy_pre", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_in_ready", 32'(in_ready), 32'd1);
        check_eq("rstmid_out_valid", 32'(out_valid), 32'd0);
        check_eq("rstmid_out_data", 32'(out_data), 32'd0);
        check_eq("rstmid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        check_eq("rstmid_no_vld", 32'(vcnt), 32'd0);
        issue("after_rst", 16'h1234, 4'd4, 1'b0);
        wait_result("after_rst", 16'h0123, 3);

        // 8-bit instance: amount 12 clamps to 8, three steps, all-zero result.
        @(negedge clk);
        check_eq("w8_rdy", 32'(in_ready8), 32'd1);
        in_valid8 = 1'b1;
        in_data8  = 8'hFF;
        in_amt8   = 4'd12;
        in_dir8   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check_eq("w8_clamp_lat", 32'(lat), 32'd4);
        check_eq("w8_clamp_data", 32'(out_data8), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
